seg7_sequencer: RTL and testbench
=================================

# seg7_sequencer

Timing and sequencing controller for the seven-segment display path. A prescaler divides `clk` down to a programmable digit rate. A digit counter steps through 0..MAX_DIGIT, up or down, under a three-state run control. The counter value is decoded to segment drive, so the block directly feeds the top-level segment pins.

## Interface
Parameters:
- `CNT_W`, 24: prescaler and compare-register width.
- `CMP_RST`, 24'd9_999_999: compare reset value; the digit period is CMP+1 clock cycles.
- `MAX_DIGIT`, 9: highest digit value. Legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  global enable. When low, all registers hold and all control inputs are ignored.
- `start`  in  1  pulse; enter RUN.
- `stop`  in  1  pulse; enter STOP.
- `step`  in  1  pulse; from STOP, perform one timed advance.
- `dir`  in  1  1 = count up, 0 = count down; sampled at each advance.
- `clear`  in  1  pulse; digit and prescaler forced to 0.
- `cmp_we`  in  1  write strobe for the compare register.
- `cmp_in`  in  CNT_W  new compare value.
- `digit`  out  4  current digit (registered).
- `seg`  out  7  segment drive. Bit 0 = a … bit 6 = g; active high; combinational from `digit`.
- `tick`  out  1  one-cycle pulse in the first cycle a new digit is shown.
- `wrap`  out  1  one-cycle pulse coincident with `tick` when the counter wrapped.
- `state`  out  2  0 = STOP, 1 = RUN, 2 = ONESHOT.
- `busy`  out  1  high when `state` ≠ STOP.

## Operation
- State machine (transitions on a clock edge with `ena`=1):
  - STOP: `start` → RUN. `step` → ONESHOT.
  - RUN: `stop` → STOP. `step` is ignored.
  - ONESHOT: `stop` → STOP with no advance. When the advance occurs → STOP. `start` → RUN, and the prescaler continues counting.
- Input priority within one cycle: `stop` > `start` > `step`.
- Prescaler `pre`:
  - In STOP, `pre` = 0.
  - In RUN or ONESHOT, `pre` increments each cycle.
  - When `pre` == `cmp`, the next edge sets `pre` to 0 and performs one advance.
- Advance:
  - Up: `digit`+1, or 0 if `digit` == MAX_DIGIT (wrap).
  - Down: `digit`−1, or MAX_DIGIT if `digit` == 0 (wrap).
- Entering RUN or ONESHOT from STOP starts with `pre` = 0. The first advance therefore occurs CMP+1 cycles after the start/step edge.
- `cmp_we`:
  - `cmp` ← `cmp_in` and `pre` ← 0 at the same edge.
  - Any advance that would have occurred on that edge is suppressed.
  - Legal in any state.
- `clear`:
  - `digit` ← 0 and `pre` ← 0.
  - Any advance on that edge is suppressed; `tick` and `wrap` stay low.
  - `state` is unchanged.
  - If `clear` and `cmp_we` occur together, both take effect.
- Segment map (a..g) for digits 0–9: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, `seg[6:0]`).
- Segment map for digits 10–15: A=77, b=7C, C=39, d=5E, E=79, F=71.
- `digit` never exceeds MAX_DIGIT, including after a `clear` or a change of `dir`.

## Timing
- Reset values: `state` = STOP, `digit` = 0, `seg` = 7'h3F, `pre` = 0, `cmp` = CMP_RST, `tick` = 0, `wrap` = 0, `busy` = 0.
- Reset is asserted asynchronously. Release is synchronous to the next rising edge after `rst_n` goes high.
- Reset mid-operation aborts any pending advance immediately.
- Advance latency: the edge after the cycle with `pre` == `cmp` updates `digit`, `seg`, `tick` and `wrap` together.
- `tick` and `wrap` are high for exactly one cycle. They are never high in consecutive cycles unless `cmp` = 0.
- With `cmp` = 0 in RUN, the block advances every cycle and `tick` stays high continuously.
- Control responses take effect at the first edge where the pulse is sampled: `start`/`stop`/`step` change `state` with 1-cycle latency.
- If `stop` arrives in the same cycle as `pre` == `cmp`, the advance is suppressed.
- With `ena` = 0, all registers hold, including `tick` and `wrap`. Resuming continues from the held `pre`.

## Test plan
- Reset, then `cmp_we` with `cmp_in`=3, then `start`, `dir`=1 → `digit` 1 at cycle 4 after start, 2 at cycle 8, …; `tick` high one cycle each time; `busy`=1.
- Same setup, run until `digit`=9 → the next advance gives `digit`=0, `seg`=3F, and `wrap`=1 for one cycle.
- `dir`=0 from `digit`=0, `cmp`=1 → after 2 cycles `digit`=9, `seg`=6F, `wrap`=1.
- In STOP, pulse `step` with `cmp`=2 → `state`=2, `digit` advances exactly once 3 cycles later, then `state`=0; a second 3-cycle wait shows no change.
- In RUN with `cmp`=5, assert `cmp_we` (`cmp_in`=1) on the cycle where `pre`=5 → no tick that edge; ticks then follow every 2 cycles.
- In RUN, hold `ena`=0 for 10 cycles, then pulse `clear`; also assert `rst_n`=0 mid-count → `digit` and `pre` freeze during `ena`=0; `clear` gives `digit`=0 with no tick; reset immediately gives all reset values.

Source files
------------

// File: rtl/seg7_sequencer.sv
// Digit-rate sequencer for the seven-segment path: prescaler, STOP/RUN/ONESHOT
// control, up/down digit counter with wrap, and combinational segment decode.
module seg7_sequencer #(
  parameter int               CNT_W     = 24,
  parameter logic [CNT_W-1:0] CMP_RST   = 24'd9_999_999,
  parameter int               MAX_DIGIT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic             clear,
  input  logic             cmp_we,
  input  logic [CNT_W-1:0] cmp_in,
  output logic [3:0]       digit,
  output logic [6:0]       seg,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ONESHOT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] pre_q;
  logic [CNT_W-1:0] cmp_q;
  logic [3:0]       digit_q;
  logic [3:0]       digit_nxt;
  logic             tick_q;
  logic             wrap_q;
  logic             adv;
  logic             wrap_hit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // stop, clear and a compare write all cancel an advance due on this edge
  always_comb begin
    adv       = (state_q != ST_STOP) && (pre_q == cmp_q) && !stop && !clear && !cmp_we;
    wrap_hit  = dir ? (digit_q == MAX_D) : (digit_q == 4'd0);
    digit_nxt = digit_q;
    if (dir) digit_nxt = wrap_hit ? 4'd0 : digit_q + 4'd1;
    else     digit_nxt = wrap_hit ? MAX_D : digit_q - 4'd1;

    state_nxt = state_q;
    case (state_q)
      ST_STOP: begin
        if (stop)       state_nxt = ST_STOP;
        else if (start) state_nxt = ST_RUN;
        else if (step)  state_nxt = ST_ONESHOT;
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_STOP;
      end
      ST_ONESHOT: begin
        if (stop)       state_nxt = ST_STOP;
        else if (start) state_nxt = ST_RUN;
        else if (adv)   state_nxt = ST_STOP;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // registered control, counters and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      pre_q   <= '0;
      cmp_q   <= CMP_RST;
      digit_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_nxt;
      if (cmp_we) cmp_q <= cmp_in;

      if (clear || cmp_we || state_q == ST_STOP || state_nxt == ST_STOP ||
          pre_q == cmp_q)
        pre_q <= '0;
      else
        pre_q <= pre_q + CNT_W'(1);

      if (clear)    digit_q <= 4'd0;
      else if (adv) digit_q <= digit_nxt;

      tick_q <= adv;
      wrap_q <= adv && wrap_hit;
    end
  end

  assign digit = digit_q;
  assign seg   = seg_decode(digit_q);
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign state = state_q;
  assign busy  = (state_q != ST_STOP);

endmodule

// File: tb/tb_seg7_sequencer.sv
// Directed bench for seg7_sequencer: walks run, wrap, down-count, one-shot,
// compare rewrite, enable hold, clear and asynchronous reset.
module tb_seg7_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, stop, step, dir, clear, cmp_we;
  logic [23:0] cmp_in;
  logic [3:0]  digit;
  logic [6:0]  seg;
  logic        tick, wrap, busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  seg7_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
    .step(step), .dir(dir), .clear(clear), .cmp_we(cmp_we), .cmp_in(cmp_in),
    .digit(digit), .seg(seg), .tick(tick), .wrap(wrap), .state(state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    dir = 1'b1; clear = 1'b0; cmp_we = 1'b0; cmp_in = '0;
    cyc(3);
    chk("rst_digit", digit, 0);
    chk("rst_seg",   seg,   'h3F);
    chk("rst_state", state, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_tick",  tick,  0);
    chk("rst_wrap",  wrap,  0);
    rst_n = 1'b1;
    cyc(1);

    // up-count, cmp=3: advance every 4 cycles
    cmp_we = 1'b1; cmp_in = 24'd3; cyc(1); cmp_we = 1'b0;
    start = 1'b1; dir = 1'b1; cyc(1); start = 1'b0;
    chk("run_state", state, 1);
    chk("run_busy",  busy,  1);
    cyc(3);
    chk("pre_adv_digit", digit, 0);
    chk("pre_adv_tick",  tick,  0);
    cyc(1);
    chk("adv1_digit", digit, 1);
    chk("adv1_seg",   seg,   'h06);
    chk("adv1_tick",  tick,  1);
    cyc(1);
    chk("adv1_tick_off", tick, 0);
    cyc(3);
    chk("adv2_digit", digit, 2);
    chk("adv2_tick",  tick,  1);
    cyc(28);
    chk("adv9_digit", digit, 9);
    chk("adv9_wrap",  wrap,  0);
    cyc(4);
    chk("upwrap_digit", digit, 0);
    chk("upwrap_seg",   seg,   'h3F);
    chk("upwrap_wrap",  wrap,  1);
    chk("upwrap_tick",  tick,  1);
    cyc(1);
    chk("upwrap_wrap_off", wrap, 0);

    // down-count from 0 with cmp=1
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_busy",  busy,  0);
    cmp_we = 1'b1; cmp_in = 24'd1; cyc(1); cmp_we = 1'b0;
    dir = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    chk("dn_wait_digit", digit, 0);
    cyc(1);
    chk("dnwrap_digit", digit, 9);
    chk("dnwrap_seg",   seg,   'h6F);
    chk("dnwrap_wrap",  wrap,  1);
    stop = 1'b1; cyc(1); stop = 1'b0;

    // one-shot step with cmp=2
    cmp_we = 1'b1; cmp_in = 24'd2; cyc(1); cmp_we = 1'b0;
    step = 1'b1; cyc(1); step = 1'b0;
    chk("os_state", state, 2);
    cyc(2);
    chk("os_wait_digit", digit, 9);
    cyc(1);
    chk("os_digit", digit, 8);
    chk("os_seg",   seg,   'h7F);
    chk("os_tick",  tick,  1);
    chk("os_done_state", state, 0);
    cyc(3);
    chk("os_hold_digit", digit, 8);
    chk("os_hold_tick",  tick,  0);

    // compare rewrite on the pre==cmp cycle suppresses that advance
    cmp_we = 1'b1; cmp_in = 24'd5; cyc(1); cmp_we = 1'b0;
    dir = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
    cyc(5);
    cmp_we = 1'b1; cmp_in = 24'd1; cyc(1); cmp_we = 1'b0;
    chk("cmpwe_tick",  tick,  0);
    chk("cmpwe_digit", digit, 8);
    cyc(1);
    chk("cmpwe_gap_tick", tick, 0);
    cyc(1);
    chk("cmpwe_adv_tick",  tick,  1);
    chk("cmpwe_adv_digit", digit, 9);
    cyc(1);
    chk("cmpwe_gap2_tick", tick, 0);
    cyc(1);
    chk("cmpwe_adv2_digit", digit, 0);
    chk("cmpwe_adv2_wrap",  wrap,  1);

    // ena low freezes everything, including pulses and control inputs
    ena = 1'b0; stop = 1'b1;
    cyc(10);
    stop = 1'b0;
    chk("ena_tick",  tick,  1);
    chk("ena_wrap",  wrap,  1);
    chk("ena_digit", digit, 0);
    chk("ena_state", state, 1);
    ena = 1'b1;
    cyc(1);
    chk("resume_tick",  tick,  0);
    chk("resume_digit", digit, 0);
    cyc(1);
    chk("resume_adv_digit", digit, 1);
    chk("resume_adv_tick",  tick,  1);

    // clear on a due advance: digit to 0, no tick, state kept
    cyc(1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_digit", digit, 0);
    chk("clr_tick",  tick,  0);
    chk("clr_wrap",  wrap,  0);
    chk("clr_state", state, 1);
    cyc(1);
    chk("clr_gap_tick", tick, 0);
    cyc(1);
    chk("clr_adv_digit", digit, 1);
    chk("clr_adv_tick",  tick,  1);

    // asynchronous reset mid-count
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digit", digit, 0);
    chk("arst_seg",   seg,   'h3F);
    chk("arst_state", state, 0);
    chk("arst_tick",  tick,  0);
    chk("arst_busy",  busy,  0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_digit", digit, 0);
    chk("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
